// File: rtl/hilo_mdu_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The EX stage drives the master side and the unit sits on the slave side.
interface hilo_mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             en;
  logic             flush;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output en, flush, mdu_op, a, b,
    input  stall, done, hi, lo
  );

  modport slave (
    input  en, flush, mdu_op, a, b,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU take 2 cycles, DIV/DIVU take WIDTH+1 cycles, and MTHI/MTLO take 1 cycle.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_mdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] a_r;     // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] b_r;     // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    count_r;
  logic             signed_r;
  logic             sa_r;
  logic             sb_r;
  logic             done_r;

  logic             is_md_s;
  logic             is_div_s;
  logic             is_signed_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             stall_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // Issue decode, operand magnitudes and the pipeline hold request
  always_comb begin
    is_div_s    = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
    is_md_s     = is_div_s || (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
    is_signed_s = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_DIV);
    abs_a_s     = (is_signed_s && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    abs_b_s     = (is_signed_s && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    stall_s     = !bus.flush && (((state_r == IDLE) && bus.en && is_md_s) ||
                                 (state_r == MUL) || (state_r == DIV));
  end

  // Full-width product of the latched operands
  always_comb begin
    ext_a_s = signed_r ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    ext_b_s = signed_r ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    prod_s  = ext_a_s * ext_b_s;
  end

  // One restoring-division step; a zero divisor falls through to q=all ones, r=dividend
  always_comb begin
    rem_sh_s  = {rem_r, a_r[WIDTH-1]};
    diff_s    = rem_sh_s[WIDTH-1:0] - b_r;
    ge_s      = rem_sh_s >= {1'b0, b_r};
    rem_nxt_s = ge_s ? diff_s : rem_sh_s[WIDTH-1:0];
    quo_nxt_s = {a_r[WIDTH-2:0], ge_s};
    q_fix_s   = (sa_r ^ sb_r) ? ({WIDTH{1'b0}} - quo_nxt_s) : quo_nxt_s;
    r_fix_s   = sa_r ? ({WIDTH{1'b0}} - rem_nxt_s) : rem_nxt_s;
  end

  // Control FSM with HI/LO and operand state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      signed_r <= 1'b0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      done_r   <= 1'b0;
    end else if (bus.flush) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.en && is_md_s) begin
            a_r      <= is_div_s ? abs_a_s : bus.a;
            b_r      <= is_div_s ? abs_b_s : bus.b;
            rem_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            signed_r <= is_signed_s;
            sa_r     <= is_signed_s && bus.a[WIDTH-1];
            sb_r     <= is_signed_s && bus.b[WIDTH-1];
            state_r  <= is_div_s ? DIV : MUL;
          end else if (bus.en && (bus.mdu_op == OP_MTHI)) begin
            hi_r <= bus.a;
          end else if (bus.en && (bus.mdu_op == OP_MTLO)) begin
            lo_r <= bus.a;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          hi_r    <= prod_s[2*WIDTH-1:WIDTH];
          lo_r    <= prod_s[WIDTH-1:0];
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DIV: begin
          rem_r   <= rem_nxt_s;
          a_r     <= quo_nxt_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(WIDTH - 1)) begin
            hi_r    <= r_fix_s;
            lo_r    <= q_fix_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= DIV;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall = stall_s;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the main ALU that is driven by the ALU decoder's `aluctrl`. It executes MULT/MULTU (2-cycle), DIV/DIVU (iterative radix-2, WIDTH+1 cycles) and MTHI/MTLO (single-cycle), and asserts a stall to hold the pipeline while a multi-cycle operation is in flight. Results are committed to HI/LO, which MFHI/MFLO read directly from `hi`/`lo`.

## Interface
- WIDTH, 32, operand/register width; DIV iterates WIDTH cycles.
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  EX-stage instruction valid (not bubble).
- flush  in  1  exception/flush of EX stage; cancels issue or in-flight op.
- mdu_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- stall  out  1  hold IF..EX; combinational.
- done  out  1  registered; high for the one cycle after HI/LO commit of a MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Issue: in IDLE with en=1, flush=0, mdu_op in {MULT,MULTU,DIV,DIVU}: latch a, b, signedness; go to MUL or DIV (DIV: count=0, load |a|, |b| for signed, raw for unsigned; record sa, sb).
- MUL: product = signed or unsigned 2·WIDTH-bit a×b of latched operands; at end of MUL cycle write hi=product[2W-1:W], lo=product[W-1:0]; go DONE.
- DIV: restoring, one quotient bit per cycle, MSB first; count 0..WIDTH-1; at edge ending count WIDTH-1 write fixed-up results, go DONE.
- Sign fixup (signed only): quotient negated if sa^sb, remainder negated if sa; negation is two's complement modulo 2^WIDTH. lo=quotient, hi=remainder.
- Divisor zero: no special case; algorithm output stands (DIVU x/0 -> lo=all ones, hi=x).
- DONE: stall=0, EX instruction retires this edge; DONE -> IDLE unconditionally (prevents re-issue of same instruction).
- MTHI/MTLO: in IDLE with en=1, flush=0: hi (or lo) <= a at this edge; no stall, no state change, done stays 0.
- stall = !flush && ((IDLE && en && op in MULT/MULTU/DIV/DIVU) || MUL || DIV).
- flush=1 in any state: next state IDLE, no HI/LO write, done=0, stall=0 that cycle.
- Opcodes 000/111 or en=0: no effect.

## Timing
- Reset: state IDLE, hi=0, lo=0, done=0, count=0; stall=0 unless issue conditions hold.
- MULT/MULTU: stall high 2 cycles (issue + MUL); HI/LO visible cycle 2 after issue; done high cycle 2.
- DIV/DIVU: stall high WIDTH+1 cycles (issue + WIDTH DIV); HI/LO visible, done high, on cycle WIDTH+1 after issue.
- MTHI/MTLO: new value visible next cycle, so a following MFHI/MFLO in EX reads it without forwarding.
- Back-to-back MULT/DIV: second enters EX in DONE cycle, issues next cycle from IDLE (one non-stall cycle between).
- Reset asserted mid-operation: immediate return to reset values; partial results discarded.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall 2 cycles, hi=0xFFFFFFFE, lo=0x00000001, done 1 pulse.
- MULT a=0xFFFFFFFE(-2) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=-7 b=2 -> stall 33 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7; DIVU a=100 b=7 -> lo=14, hi=2.
- MTHI a=0x1234, then MTLO a=0x5678 back-to-back -> no stall; hi=0x1234, lo=0x5678 one cycle after each.
- DIV issued, flush at DIV count 10 -> stall drops that cycle, state IDLE, hi/lo retain prior values, done stays 0; resetn pulsed mid-MUL -> hi=lo=0, stall=0.
